// File: rtl/gf_pkg.sv
// gf_pkg: shared GF(2^N) constants, FSM state type and squaring helper
package gf_pkg;
  localparam int GF_N = 6;
  localparam logic [6:0] GF_POLY = 7'b1000011;
  typedef enum logic [1:0] {IDLE, RUN, DONE} gf_state_e;
  function automatic int gf_ew(input int n);
    return n;
  endfunction
  function automatic int gf_cw(input int ew);
    return ew > 1 ? $clog2(ew) : 1;
  endfunction
  function automatic logic [15:0] gf_sq(input logic [15:0] a, input logic [16:0] poly, input int n);
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (i < n) p[2*i] = a[i];
    for (int i = 30; i >= 0; i--)
      if (i >= n && p[i]) p = p ^ ({15'b0, poly} << (i - n));
    return p[15:0];
  endfunction
endpackage

// File: rtl/gf_mul_poly.sv
// gf_mul_poly: combinational a*b mod POLY over GF(2^N), shift-and-add
module gf_mul_poly #(
  parameter int N = 6,
  parameter logic [N:0] POLY = 7'b1000011
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  // Horner over b from MSB: r = r*alpha mod POLY, then add a if b bit set
  always_comb begin
    y = '0;
    for (int i = N - 1; i >= 0; i--)
      y = {y[N-2:0], 1'b0} ^ (y[N-1] ? POLY[N-1:0] : '0) ^ (b[i] ? a : '0);
  end
endmodule

// File: rtl/gf_power_seq.sv
// gf_power_seq: sequential y = x^e over GF(2^N), left-to-right square-and-multiply
module gf_power_seq
  import gf_pkg::*;
#(
  parameter int N = GF_N,
  parameter logic [N:0] POLY = GF_POLY,
  parameter int EW = gf_ew(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_x,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_y,
  output logic          busy
);
  localparam int CW = gf_cw(EW);
  gf_state_e state, nxt;
  logic [N-1:0] x, acc, sq, bsel, prod;
  logic [EW-1:0] e;
  logic [CW-1:0] cnt;
  logic [15:0] sq_full;
  // squarer feeds the multiplier within the same cycle
  always_comb begin
    sq_full = gf_sq(16'(acc), 17'(POLY), N);
    sq = sq_full[N-1:0];
    bsel = e[cnt] ? x : N'(1);
  end
  gf_mul_poly #(.N(N), .POLY(POLY)) u_mul (.a(sq), .b(bsel), .y(prod));
  // next state and handshake outputs, all state-based
  always_comb begin
    nxt = (state == IDLE && in_valid) ? RUN :
          (state == RUN && cnt == '0) ? DONE :
          (state == DONE && out_ready) ? IDLE : state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    out_y = acc;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // operand latch and one exponent bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x <= '0;
      e <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      x <= in_x;
      e <= in_exp;
      acc <= N'(1);
      cnt <= CW'(EW - 1);
    end else if (state == RUN) begin
      acc <= prod;
      cnt <= cnt - 1'b1;
    end
endmodule

// File: tb/tb_gf_power_seq.sv
// tb_gf_power_seq: scoreboard bench for gf_power_seq at N=6, POLY=x^6+x+1
module tb_gf_power_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, out_valid, in_ready, busy;
  logic [5:0] in_x = 0, in_exp = 0, out_y;
  int checks = 0, fails = 0;
  logic [5:0] q[$];

  gf_power_seq dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [5:0] m_mul(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] r;
    r = 0;
    for (int i = 0; i < 6; i++) if (b[i]) r = r ^ (12'(a) << i);
    for (int i = 10; i >= 6; i--) if (r[i]) r = r ^ (12'h43 << (i - 6));
    return r[5:0];
  endfunction

  function automatic logic [5:0] m_pow(input logic [5:0] x, input logic [5:0] e);
    logic [5:0] r;
    r = 1;
    for (int k = 0; k < int'(e); k++) r = m_mul(r, x);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [5:0] x, input logic [5:0] e);
    int n;
    n = 0;
    q.push_back(m_pow(x, e));
    in_x = x; in_exp = e; in_valid = 1;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      checks++; fails++;
      $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
    end
    tick();
    in_valid = 0;
  endtask

  task automatic collect(output logic [5:0] y, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    y = out_y;
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; #12;
    checks++;
    if ({in_ready, out_valid, busy, out_y} !== {3'b100, 6'd0}) begin
      fails++;
      $display("FAIL reset got rdy=%b val=%b busy=%b y=%0d required 1 0 0 0", in_ready, out_valid, busy, out_y);
    end
    @(negedge clk); rst_n = 1; tick();
  endtask

  task automatic test_latency();
    logic [5:0] y, exp_y; int cyc;
    issue(6'd2, 6'd6);
    collect(y, cyc);
    exp_y = q.pop_front();
    checks++;
    if (y !== exp_y || y !== 6'd3) begin fails++; $display("FAIL alpha6 got %0d required %0d", y, exp_y); end
    checks++;
    if (cyc !== 6) begin fails++; $display("FAIL latency got %0d edges required 6", cyc); end
  endtask

  task automatic test_sweep();
    logic [5:0] y, exp_y; int cyc, bad;
    issue(6'd2, 6'd13);
    collect(y, cyc);
    exp_y = q.pop_front();
    checks++;
    if (y !== 6'd10 || exp_y !== 6'd10) begin fails++; $display("FAIL alpha13 got %0d required 10", y); end
    bad = 0;
    for (int x = 0; x < 64; x++) begin
      issue(6'(x), 6'd13);
      collect(y, cyc);
      exp_y = q.pop_front();
      checks++;
      if (y !== exp_y) begin fails++; bad++; if (bad < 5) $display("FAIL sweep13 x=%0d got %0d required %0d", x, y, exp_y); end
    end
  endtask

  task automatic test_boundary();
    logic [5:0] xs[3] = '{6'd0, 6'd0, 6'd37};
    logic [5:0] es[3] = '{6'd0, 6'd5, 6'd63};
    logic [5:0] rs[3] = '{6'd1, 6'd0, 6'd1};
    logic [5:0] y, exp_y; int cyc;
    for (int i = 0; i < 3; i++) begin
      issue(xs[i], es[i]);
      collect(y, cyc);
      exp_y = q.pop_front();
      checks++;
      if (y !== rs[i] || y !== exp_y) begin fails++; $display("FAIL boundary x=%0d e=%0d got %0d required %0d", xs[i], es[i], y, rs[i]); end
    end
  endtask

  task automatic test_inverse();
    logic [5:0] y, exp_y; int cyc;
    for (int x = 1; x < 64; x++) begin
      issue(6'(x), 6'd62);
      collect(y, cyc);
      exp_y = q.pop_front();
      checks++;
      if (m_mul(6'(x), y) !== 6'd1 || y !== exp_y) begin
        fails++; $display("FAIL inverse x=%0d got %0d required %0d", x, y, exp_y);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp_y; int n;
    issue(6'd7, 6'd11);
    exp_y = q.pop_front();
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    in_x = 6'd9; in_exp = 6'd3; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1 || out_y !== exp_y || in_ready !== 0) begin
        fails++; $display("FAIL backpressure cyc=%0d val=%b y=%0d rdy=%b required 1 %0d 0", i, out_valid, out_y, in_ready, exp_y);
      end
      tick();
    end
    in_valid = 0; out_ready = 1; tick(); out_ready = 0;
    checks++;
    if (out_valid !== 0 || busy !== 0 || in_ready !== 1) begin
      fails++; $display("FAIL bp_release val=%b busy=%b rdy=%b required 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] y, exp_y; int cyc, seen;
    in_x = 6'd2; in_exp = 6'd13; in_valid = 1; tick(); in_valid = 0;
    tick(); tick();
    #2 rst_n = 0; #1;
    checks++;
    if ({in_ready, out_valid, busy, out_y} !== {3'b100, 6'd0}) begin
      fails++; $display("FAIL async_reset rdy=%b val=%b busy=%b y=%0d required 1 0 0 0", in_ready, out_valid, busy, out_y);
    end
    @(negedge clk); rst_n = 1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (out_valid) seen++; end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL post_reset_valid got %0d cycles required 0", seen); end
    issue(6'd2, 6'd13);
    collect(y, cyc);
    exp_y = q.pop_front();
    checks++;
    if (y !== 6'd10 || y !== exp_y) begin fails++; $display("FAIL after_reset got %0d required 10", y); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sweep();
    test_boundary();
    test_inverse();
    test_backpressure();
    test_async_reset();
    checks++;
    if (q.size() !== 0) begin fails++; $display("FAIL scoreboard_left got %0d required 0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
